// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the serial display shifter.
//   - FSM state encoding (IDLE/SHIFT/LATCH/DONE)
//   - default frame width and serial half-period, also used by the display mux
//   - cnt_w(): counter width helper that never returns zero
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } p2s_state_e;

    localparam int P2S_DATA_WIDTH = 64;
    localparam int P2S_DIV        = 2;

    // $clog2(1) is 0, which would give a zero-width counter when DIV=1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/p2s_shift_out_64_if.sv
// p2s_shift_out_64_if: bus between the display-data mux side and the
// serial shifter, plus the serial pins to the display chain.
//   master: drives start/par_data, observes status and serial pins
//   slave : the shifter (accepts start/par_data, drives everything else)
interface p2s_shift_out_64_if #(parameter int DATA_WIDTH = p2s_pkg::P2S_DATA_WIDTH);
    logic                  start;
    logic [DATA_WIDTH-1:0] par_data;
    logic                  busy;
    logic                  done;
    logic                  s_clk;
    logic                  s_data;
    logic                  s_latch;
    logic                  s_clr_n;

    modport master (output start, par_data,
                    input  busy, done, s_clk, s_data, s_latch, s_clr_n);
    modport slave  (input  start, par_data,
                    output busy, done, s_clk, s_data, s_latch, s_clr_n);
endinterface

// File: rtl/p2s_half_tick.sv
// p2s_half_tick: emits a one-cycle tick every DIV clk cycles while enabled.
//   clk, rst : clock, async active-high reset
//   en       : count while high (holds otherwise)
//   restart  : synchronous clear, takes priority over en
//   tick     : high in the last cycle of each DIV-cycle half period
module p2s_half_tick
    import p2s_pkg::*;
#(
    parameter int DIV = P2S_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/p2s_shift_out_64.sv
// p2s_shift_out_64: snapshots a DATA_WIDTH-bit word on start and shifts it
// MSB-first to a cascaded shift-register display chain, then strobes the
// storage latch and pulses done.
//   clk, rst        : clock, async active-high reset
//   bus.start       : accept request (taken in IDLE or DONE)
//   bus.par_data    : word from the display mux, sampled on the accepting edge
//   bus.busy        : high through SHIFT and LATCH
//   bus.done        : one-cycle pulse after the latch strobe
//   bus.s_clk/s_data: serial clock/data, one bit per 2*DIV clk cycles
//   bus.s_latch     : storage strobe, DIV cycles wide
//   bus.s_clr_n     : chain clear, low during reset
// Build option: define P2S_AUTO_REFRESH_EN to restart a new frame from DONE
// every time, re-sampling par_data, so the display tracks the mux live.
module p2s_shift_out_64
    import p2s_pkg::*;
#(
    parameter int DATA_WIDTH = P2S_DATA_WIDTH,
    parameter int DIV        = P2S_DIV
) (
    input logic                clk,
    input logic                rst,
    p2s_shift_out_64_if.slave  bus
);
    localparam int            BW       = cnt_w(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    p2s_state_e            state, state_n;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bitcnt;
    logic                  s_clk_q;
    logic                  clr_n_q;
    logic                  tick;
    logic                  load;
    logic                  bit_end;

    p2s_half_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      ((state == SHIFT) || (state == LATCH)),
        .restart (load),
        .tick    (tick)
    );

    // A bit ends on the tick that closes its high phase.
    assign bit_end = (state == SHIFT) && tick && s_clk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_end && (bitcnt == LAST_BIT)) state_n = LATCH;
            end
            LATCH: begin
                if (tick) state_n = DONE;
            end
            DONE: begin
`ifdef P2S_AUTO_REFRESH_EN
                load    = 1'b1;
                state_n = SHIFT;
`else
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // Data shifts on the same edge that drops s_clk, so s_data only ever
    // moves while s_clk is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bitcnt  <= '0;
            s_clk_q <= 1'b0;
            clr_n_q <= 1'b0;
        end else begin
            clr_n_q <= 1'b1;
            if (load) begin
                shreg   <= bus.par_data;
                bitcnt  <= '0;
                s_clk_q <= 1'b0;
            end else if (state == SHIFT) begin
                if (tick) s_clk_q <= ~s_clk_q;
                if (bit_end) begin
                    shreg  <= {shreg[DATA_WIDTH-2:0], 1'b0};
                    bitcnt <= bitcnt + BW'(1);
                end
            end else begin
                s_clk_q <= 1'b0;
            end
        end
    end

    assign bus.busy    = (state == SHIFT) || (state == LATCH);
    assign bus.done    = (state == DONE);
    assign bus.s_clk   = s_clk_q;
    assign bus.s_data  = (state == SHIFT) && shreg[DATA_WIDTH-1];
    assign bus.s_latch = (state == LATCH);
    assign bus.s_clr_n = clr_n_q;
endmodule

// File: tb/tb_p2s_shift_out_64.sv
module tb_p2s_shift_out_64;
    localparam int W   = 64;
    localparam int DIV = 2;
    localparam int LAT = 259;   // 1 + 2*2*64 + 2

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    p2s_shift_out_64_if #(.DATA_WIDTH(W)) bus ();

    p2s_shift_out_64 #(.DATA_WIDTH(W), .DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] data;
        int          done_cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [63:0] cap = '0;
    int   rises = 0, viol = 0, latch_run = 0, latch_len = 0;
    int   latch_pulses = 0, done_cnt = 0;
    logic prev_sclk = 1'b0, prev_sdata = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            cap = '0; rises = 0; viol = 0; latch_run = 0; latch_len = 0;
            prev_sclk = 1'b0; prev_sdata = 1'b0;
        end else begin
            if (bus.s_clk && !prev_sclk) begin
                cap = {cap[62:0], bus.s_data};
                rises++;
            end
            if (bus.s_clk && prev_sclk && (bus.s_data !== prev_sdata)) viol++;
            if (bus.s_latch) latch_run++;
            else if (latch_run != 0) begin
                latch_len = latch_run;
                latch_run = 0;
                latch_pulses++;
            end
            if (bus.done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    chk("done_with_empty_queue", 64'(q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("frame_data", cap, e.data);
                    chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    chk("sclk_rises", 64'(rises), 64'd64);
                    chk("latch_len", 64'(latch_len), 64'(DIV));
                    chk("busy_in_done", 64'(bus.busy), 64'd0);
                    chk("sdata_moved_while_sclk_high", 64'(viol), 64'd0);
                end
                cap = '0; rises = 0; viol = 0; latch_len = 0;
            end
            prev_sclk  = bus.s_clk;
            prev_sdata = bus.s_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        if (q.size() != 0) chk("drain_timeout_left", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_idle_outputs(input string tag, input logic clr_n_exp);
        chk({tag, "_busy"},    64'(bus.busy),    64'd0);
        chk({tag, "_done"},    64'(bus.done),    64'd0);
        chk({tag, "_s_clk"},   64'(bus.s_clk),   64'd0);
        chk({tag, "_s_data"},  64'(bus.s_data),  64'd0);
        chk({tag, "_s_latch"}, 64'(bus.s_latch), 64'd0);
        chk({tag, "_s_clr_n"}, 64'(bus.s_clr_n), 64'(clr_n_exp));
    endtask

    // Pulse start for one cycle with d and schedule the expected frame.
    task automatic send(input logic [63:0] d, output int t);
        t = cyc;
        bus.par_data = d;
        bus.start    = 1'b1;
        q.push_back('{d, t + LAT});
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, d0, l0;
        bus.start    = 1'b0;
        bus.par_data = '0;

        // Reset state
        repeat (3) step();
        chk_idle_outputs("reset", 1'b0);
        rst = 1'b0;
        chk("clr_n_before_edge", 64'(bus.s_clr_n), 64'd0);
        step();
        chk_idle_outputs("post_reset", 1'b1);
        repeat (3) step();

`ifdef P2S_AUTO_REFRESH_EN
        // Single start; each later frame carries par_data from the prior DONE cycle.
        send(64'h1111_2222_3333_4444, t);
        q.push_back('{64'hAAAA_5555_0F0F_F0F0, t + 2*LAT});
        q.push_back('{64'h0123_4567_89AB_CDEF, t + 3*LAT});
        bus.par_data = 64'hAAAA_5555_0F0F_F0F0;
        go_to(t + LAT + 1);
        chk("auto_busy_after_done", 64'(bus.busy), 64'd1);
        go_to(t + 300);
        bus.par_data = 64'h0123_4567_89AB_CDEF;
        wait_drain(1000);
`else
        // Single-bit-at-each-end pattern
        send(64'h8000_0000_0000_0001, t);
        wait_drain(400);
        repeat (5) step();

        // Mixed pattern
        send(64'h0123_4567_89AB_CDEF, t);
        wait_drain(400);
        repeat (5) step();

        // Snapshot held across par_data change; start while busy ignored
        d0 = done_cnt;
        send(64'h5A5A_C3C3_0000_FFFF, t);
        bus.par_data = 64'hFFFF_FFFF_FFFF_FFFF;
        go_to(t + 50);
        chk("busy_mid_frame", 64'(bus.busy), 64'd1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_drain(400);
        repeat (300) step();
        chk("single_done_count", 64'(done_cnt - d0), 64'd1);

        // start held high: back-to-back frames, DONE cycle accepts the next
        t = cyc;
        bus.par_data = 64'hDEAD_BEEF_CAFE_F00D;
        bus.start    = 1'b1;
        q.push_back('{64'hDEAD_BEEF_CAFE_F00D, t + LAT});
        q.push_back('{64'h1357_9BDF_2468_ACE0, t + 2*LAT});
        q.push_back('{64'hFEDC_BA98_7654_3210, t + 3*LAT});
        step();
        bus.par_data = 64'h1357_9BDF_2468_ACE0;
        go_to(t + LAT);
        chk("b2b_busy_in_done", 64'(bus.busy), 64'd0);
        step();
        chk("b2b_busy_after_done", 64'(bus.busy), 64'd1);
        chk("b2b_s_clk_after_done", 64'(bus.s_clk), 64'd0);
        go_to(t + 300);
        bus.par_data = 64'hFEDC_BA98_7654_3210;
        go_to(t + 600);
        bus.start = 1'b0;
        wait_drain(400);
        step();
        chk("b2b_idle_busy", 64'(bus.busy), 64'd0);
        repeat (5) step();

        // Reset during bit 20 aborts the frame, no latch
        t = cyc;
        bus.par_data = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        go_to(t + 82);
        chk("busy_before_abort", 64'(bus.busy), 64'd1);
        d0 = done_cnt;
        l0 = latch_pulses;
        rst = 1'b1;
        #1;
        chk_idle_outputs("abort", 1'b0);
        step();
        step();
        rst = 1'b0;
        chk("abort_clr_n_held", 64'(bus.s_clr_n), 64'd0);
        step();
        chk_idle_outputs("after_abort", 1'b1);
        repeat (300) step();
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_no_latch", 64'(latch_pulses - l0), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
